// File: rtl/bitmask_index_serializer.sv
// bitmask_index_serializer: accepts a WIDTH-bit multi-hot vector and emits the
// index of every set bit, one per beat, with a last flag and the popcount.
// Optional macro BITSER_MSB_FIRST_EN: scan highest set bit first instead of
// lowest set bit first. Ports and timing are identical in both builds.
module bitmask_index_serializer #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic [IDXW:0]    out_count,
  output logic             zero_err
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDXW:0]    count_q, count_d;
  logic             zero_err_q, zero_err_d;

  logic             accept;
  logic             beat;
  logic [IDXW:0]    in_popcount;

  // State register; reset discards any pending vector immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      count_q    <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      zero_err_q <= zero_err_d;
    end
  end

  // Population count of the incoming vector, captured on accept.
  always_comb begin
    in_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_popcount = in_popcount + (IDXW+1)'(in_data[i]);
    end
  end

  // Next-state: retire the emitted bit on a beat, then let an accept override.
  always_comb begin
    accept     = in_valid & in_ready;
    beat       = out_valid & out_ready;
    state_d    = state_q;
    pending_d  = pending_q;
    count_d    = count_q;
    zero_err_d = 1'b0;
    if (beat) begin
      pending_d[out_idx] = 1'b0;
      if (out_last) begin
        state_d = IDLE;
        count_d = '0;
      end
    end
    if (accept) begin
      if (in_data != '0) begin
        state_d   = SCAN;
        pending_d = in_data;
        count_d   = in_popcount;
      end else begin
        state_d    = IDLE;
        pending_d  = '0;
        count_d    = '0;
        zero_err_d = 1'b1;
      end
    end
  end

  // Outputs: index picked straight from the pending mask; in_ready reopens on the final beat.
  always_comb begin
    out_idx = '0;
`ifdef BITSER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) out_idx = IDXW'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) out_idx = IDXW'(i);
    end
`endif
    out_last  = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    out_valid = (state_q == SCAN);
    out_count = count_q;
    zero_err  = zero_err_q;
    in_ready  = (state_q == IDLE) | (out_valid & out_ready & out_last);
  end

endmodule

// File: tb/tb_bitmask_index_serializer.sv
// Directed testbench for bitmask_index_serializer (WIDTH=8).
// Honours BITSER_MSB_FIRST_EN for the expected scan order.
module tb_bitmask_index_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic [3:0] out_count;
  logic       zero_err;

  int checks = 0;
  int errors = 0;

  bitmask_index_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_count (out_count),
    .zero_err  (zero_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k-th set bit of v in the expected scan order.
  function automatic int expIdx(input logic [7:0] v, input int k);
    int n;
    n = 0;
`ifdef BITSER_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) begin
`else
    for (int i = 0; i < 8; i++) begin
`endif
      if (v[i]) begin
        if (n == k) return i;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic checkBeat(input string tag, input logic [7:0] v, input int k, input logic last, input int cnt);
    checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " idx"},   32'(out_idx),   32'(expIdx(v, k)));
    checkOutput({tag, " last"},  32'(out_last),  32'(last));
    checkOutput({tag, " count"}, 32'(out_count), 32'(cnt));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_idx",   32'(out_idx),   32'd0);
    checkOutput("rst out_last",  32'(out_last),  32'd0);
    checkOutput("rst out_count", 32'(out_count), 32'd0);
    checkOutput("rst zero_err",  32'(zero_err),  32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);

    // Single-bit vector 0x01
    applyStimulus(1'b1, 8'h01, 1'b1);
    checkOutput("t1 in_ready", 32'(in_ready), 32'd1);
    step();
    applyStimulus(1'b0, 8'hFE, 1'b1);
    checkBeat("t1 beat0", 8'h01, 0, 1'b1, 1);
    checkOutput("t1 in_ready last", 32'(in_ready), 32'd1);
    step();
    checkOutput("t1 idle valid", 32'(out_valid), 32'd0);
    checkOutput("t1 idle in_ready", 32'(in_ready), 32'd1);

    // 0xA5 with out_ready held high
    applyStimulus(1'b1, 8'hA5, 1'b1);
    step();
    applyStimulus(1'b0, 8'h5A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkBeat($sformatf("t2 beat%0d", k), 8'hA5, k, (k == 3), 4);
      step();
    end
    checkOutput("t2 idle valid", 32'(out_valid), 32'd0);

    // 0xFF with stalls on every odd beat
    applyStimulus(1'b1, 8'hFF, 1'b1);
    step();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int s = 0; s < 2; s++) begin
          checkBeat($sformatf("t3 stall%0d.%0d", k, s), 8'hFF, k, (k == 7), 8);
          checkOutput($sformatf("t3 stall%0d.%0d in_ready", k, s), 32'(in_ready), 32'd0);
          step();
        end
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkBeat($sformatf("t3 beat%0d", k), 8'hFF, k, (k == 7), 8);
      step();
    end
    checkOutput("t3 idle valid", 32'(out_valid), 32'd0);

    // Zero vector then 0x80
    applyStimulus(1'b1, 8'h00, 1'b1);
    step();
    applyStimulus(1'b0, 8'h80, 1'b1);
    checkOutput("t4 zero_err pulse", 32'(zero_err), 32'd1);
    checkOutput("t4 no beat", 32'(out_valid), 32'd0);
    step();
    checkOutput("t4 zero_err clear", 32'(zero_err), 32'd0);
    checkOutput("t4 still idle", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h80, 1'b1);
    step();
    applyStimulus(1'b0, 8'h01, 1'b1);
    checkBeat("t4 beat0", 8'h80, 0, 1'b1, 1);
    step();
    checkOutput("t4 idle valid", 32'(out_valid), 32'd0);

    // Back-to-back 0x06 then 0x81
    applyStimulus(1'b1, 8'h06, 1'b1);
    step();
    applyStimulus(1'b1, 8'h81, 1'b1);
    checkOutput("t5 in_ready mid", 32'(in_ready), 32'd0);
    checkBeat("t5 a0", 8'h06, 0, 1'b0, 2);
    step();
    checkBeat("t5 a1", 8'h06, 1, 1'b1, 2);
    checkOutput("t5 in_ready last", 32'(in_ready), 32'd1);
    step();
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkBeat("t5 b0", 8'h81, 0, 1'b0, 2);
    step();
    checkBeat("t5 b1", 8'h81, 1, 1'b1, 2);
    step();
    checkOutput("t5 idle valid", 32'(out_valid), 32'd0);

    // Reset in the middle of 0xF0
    applyStimulus(1'b1, 8'hF0, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("t6 beat0", 8'hF0, 0, 1'b0, 4);
    step();
    checkBeat("t6 beat1", 8'hF0, 1, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst valid", 32'(out_valid), 32'd0);
    checkOutput("t6 rst count", 32'(out_count), 32'd0);
    checkOutput("t6 rst idx", 32'(out_idx), 32'd0);
    checkOutput("t6 rst last", 32'(out_last), 32'd0);
    step();
    checkOutput("t6 held valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("t6 post valid", 32'(out_valid), 32'd0);
    checkOutput("t6 post in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 8'h02, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("t6 beat", 8'h02, 0, 1'b1, 1);
    step();
    checkOutput("t6 idle valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
